// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - default sizing constants and prescaler width helper
package counter_pkg;

  localparam int DEF_DIGITS = 2;
  localparam int DEF_DW     = 4;
  localparam int DEF_MOD    = 10;
  localparam int DEF_DIV    = 25000000;

  // A divide-by-1 prescaler still needs one flop so the compare stays well formed.
  function automatic int presc_width(input int div);
    if (div <= 2) begin
      return 1;
    end
    return $clog2(div);
  endfunction

endpackage

// File: rtl/modn_digit.sv
// rtl/modn_digit.sv - one modulo-MOD up/down digit with terminal-value flag
module modn_digit #(
  parameter int DW  = 4,
  parameter int MOD = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          up,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] q,
  output logic          at_term
);

  localparam logic [DW-1:0] LAST  = DW'(MOD - 1);
  localparam logic [DW:0]   MOD_X = (DW + 1)'(MOD);

  logic [DW-1:0] r_q;
  logic          w_ld_legal;
  logic [DW-1:0] w_ld_q;
  logic [DW-1:0] w_next_up;
  logic [DW-1:0] w_next_dn;

  // Out-of-range load digits collapse to 0 so q never leaves 0..MOD-1.
  assign w_ld_legal = ({1'b0, ld_val} < MOD_X);
  assign w_ld_q     = w_ld_legal ? ld_val : '0;
  assign w_next_up  = (r_q == LAST) ? '0 : r_q + DW'(1);
  assign w_next_dn  = (r_q == '0) ? LAST : r_q - DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_ld_q;
    end else if (step) begin
      r_q <= up ? w_next_up : w_next_dn;
    end
  end

  assign q       = r_q;
  assign at_term = up ? (r_q == LAST) : (r_q == '0);

endmodule

// File: rtl/cascade_modn_counter.sv
// rtl/cascade_modn_counter.sv - prescaled cascade of modulo-N digits with wrap carry
module cascade_modn_counter
  import counter_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DW     = DEF_DW,
  parameter int MOD    = DEF_MOD,
  parameter int DIV    = DEF_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tick,
  output logic                 carry
);

  localparam int            PW         = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0]   r_presc;
  logic            r_carry;
  logic            w_presc_term;
  logic            w_tick;
  logic [DIGITS:0] w_chain;
  logic [DIGITS-1:0] w_at_term;

  assign w_presc_term = (r_presc == PRESC_LAST);
  assign w_tick       = en & w_presc_term & ~load & ~rst;
  assign w_chain[0]   = w_tick;

  // Load and reset both restart the interval so the next step is a full DIV away.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= w_presc_term ? '0 : r_presc + PW'(1);
    end
  end

  // A step that rolls through every digit is exactly a full wrap in the current direction.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_chain[DIGITS];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DW-1:0] w_q;

    modn_digit #(
      .DW (DW),
      .MOD(MOD)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (w_chain[i]),
      .up     (up),
      .load   (load),
      .ld_val (load_val[i*DW +: DW]),
      .q      (w_q),
      .at_term(w_at_term[i])
    );

    assign count[i*DW +: DW] = w_q;
    assign w_chain[i+1]      = w_chain[i] & w_at_term[i];
  end

  assign tick  = w_tick;
  assign carry = r_carry;

endmodule

// File: tb/tb_cascade_modn_counter.sv
// tb/tb_cascade_modn_counter.sv - directed checks of cascade_modn_counter in three configurations
module tb_cascade_modn_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] count1, count4, count16;
  logic       tick1, tick4, tick16;
  logic       carry1, carry4, carry16;

  int errors = 0;
  int checks = 0;

  cascade_modn_counter #(.DIGITS(2), .DW(4), .MOD(10), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count1), .tick(tick1), .carry(carry1)
  );

  cascade_modn_counter #(.DIGITS(2), .DW(4), .MOD(10), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count4), .tick(tick4), .carry(carry4)
  );

  cascade_modn_counter #(.DIGITS(2), .DW(4), .MOD(16), .DIV(1)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count16), .tick(tick16), .carry(carry16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h33;
    next_edge();
    next_edge();
    checks++; if (count1 !== 8'h00) begin errors++; $display("FAIL reset_count1 got=%h exp=00", count1); end
    checks++; if (carry1 !== 1'b0) begin errors++; $display("FAIL reset_carry1 got=%b exp=0", carry1); end
    checks++; if (tick1 !== 1'b0) begin errors++; $display("FAIL reset_tick1 got=%b exp=0", tick1); end
    checks++; if (count4 !== 8'h00) begin errors++; $display("FAIL reset_count4 got=%h exp=00", count4); end
    checks++; if (count16 !== 8'h00) begin errors++; $display("FAIL reset_count16 got=%h exp=00", count16); end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_up_sweep();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    next_edge();
    rst = 1'b0; en = 1'b1;
    for (int j = 1; j <= 100; j++) begin
      next_edge();
      checks++;
      if (count1 !== bcd(j % 100)) begin
        errors++; $display("FAIL up_sweep_count step=%0d got=%h exp=%h", j, count1, bcd(j % 100));
      end
      checks++;
      if (carry1 !== (j == 100)) begin
        errors++; $display("FAIL up_sweep_carry step=%0d got=%b exp=%b", j, carry1, (j == 100));
      end
    end
  endtask

  task automatic test_down();
    up = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      next_edge();
      checks++;
      if (count1 !== bcd((100 - j) % 100)) begin
        errors++; $display("FAIL down_count step=%0d got=%h exp=%h", j, count1, bcd((100 - j) % 100));
      end
      checks++;
      if (carry1 !== (j == 1)) begin
        errors++; $display("FAIL down_carry step=%0d got=%b exp=%b", j, carry1, (j == 1));
      end
    end
    up = 1'b1;
  endtask

  task automatic test_prescale();
    bit en_s [20] = '{1,1,1,1,1,1,0,0,0,1,1,1,1,1,1,1,1,1,1,1};
    int p;
    int cnt;
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
    next_edge();
    rst = 1'b0;
    p = 0; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      en = en_s[c];
      up = (p == 3) ? 1'b1 : c[0];
      #1;
      checks++;
      if (tick4 !== (en && p == 3)) begin
        errors++; $display("FAIL presc_tick cycle=%0d got=%b exp=%b", c, tick4, (en && p == 3));
      end
      checks++;
      if (count4 !== bcd(cnt)) begin
        errors++; $display("FAIL presc_count cycle=%0d got=%h exp=%h", c, count4, bcd(cnt));
      end
      next_edge();
      if (en) begin
        if (p == 3) begin p = 0; cnt++; end
        else p++;
      end
    end
    up = 1'b1;
    checks++;
    if (count4 !== 8'h04) begin
      errors++; $display("FAIL presc_total got=%h exp=04", count4);
    end
  endtask

  task automatic test_load();
    bit found;
    en = 1'b1; up = 1'b1; load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (tick4 === 1'b1) found = 1'b1;
      else next_edge();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL load_wait_tick got=timeout exp=tick");
    end
    load = 1'b1; load_val = 8'h47;
    #1;
    checks++; if (tick4 !== 1'b0) begin errors++; $display("FAIL load_tick_gated got=%b exp=0", tick4); end
    next_edge();
    checks++; if (count4 !== 8'h47) begin errors++; $display("FAIL load_count4 got=%h exp=47", count4); end
    checks++; if (count1 !== 8'h47) begin errors++; $display("FAIL load_count1 got=%h exp=47", count1); end
    checks++; if (carry4 !== 1'b0) begin errors++; $display("FAIL load_carry4 got=%b exp=0", carry4); end
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      next_edge();
      checks++;
      if (count4 !== 8'h47) begin
        errors++; $display("FAIL load_hold k=%0d got=%h exp=47", k, count4);
      end
    end
    next_edge();
    checks++; if (count4 !== 8'h48) begin errors++; $display("FAIL load_next_step got=%h exp=48", count4); end
    en = 1'b0; load = 1'b1; load_val = 8'h5C;
    next_edge();
    load = 1'b0;
    checks++; if (count4 !== 8'h50) begin errors++; $display("FAIL load_clip4 got=%h exp=50", count4); end
    checks++; if (count1 !== 8'h50) begin errors++; $display("FAIL load_clip1 got=%h exp=50", count1); end
    checks++; if (count16 !== 8'h5C) begin errors++; $display("FAIL load_hex16 got=%h exp=5c", count16); end
  endtask

  task automatic test_rst_load();
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
    next_edge();
    rst = 1'b0; en = 1'b1;
    for (int j = 0; j < 98; j++) next_edge();
    checks++; if (count1 !== 8'h98) begin errors++; $display("FAIL rl_pre got=%h exp=98", count1); end
    rst = 1'b1; load = 1'b1; load_val = 8'h47;
    next_edge();
    checks++; if (count1 !== 8'h00) begin errors++; $display("FAIL rl_count got=%h exp=00", count1); end
    checks++; if (carry1 !== 1'b0) begin errors++; $display("FAIL rl_carry got=%b exp=0", carry1); end
    checks++; if (count4 !== 8'h00) begin errors++; $display("FAIL rl_count4 got=%h exp=00", count4); end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_binary();
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
    next_edge();
    rst = 1'b0; en = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      next_edge();
      checks++;
      if (count16 !== 8'(j % 256)) begin
        errors++; $display("FAIL bin_count step=%0d got=%h exp=%h", j, count16, 8'(j % 256));
      end
      checks++;
      if (carry16 !== (j == 256)) begin
        errors++; $display("FAIL bin_carry step=%0d got=%b exp=%b", j, carry16, (j == 256));
      end
    end
    up = 1'b0;
    next_edge();
    checks++; if (count16 !== 8'hFF) begin errors++; $display("FAIL bin_down_count got=%h exp=ff", count16); end
    checks++; if (carry16 !== 1'b1) begin errors++; $display("FAIL bin_down_carry got=%b exp=1", carry16); end
    next_edge();
    checks++; if (carry16 !== 1'b0) begin errors++; $display("FAIL bin_carry_clear got=%b exp=0", carry16); end
    en = 1'b0; up = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    test_reset();
    test_up_sweep();
    test_down();
    test_prescale();
    test_load();
    test_rst_load();
    test_binary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cascade_modn_counter.md
CASCADE_MODN_COUNTER -- requirements
Module: cascade_modn_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of cascaded digits.
REQ-002 SHALL have parameter DW, default 4: bits per digit.
REQ-003 SHALL have parameter MOD, default 10: modulus per digit; legal range 2..2**DW.
REQ-004 SHALL have parameter DIV, default 25000000: prescale divisor; legal range >= 1.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port en, input, 1: run enable; gates the prescaler.
REQ-008 SHALL have port up, input, 1: direction; 1 = count up, 0 = count down.
REQ-009 SHALL have port load, input, 1: synchronous parallel load strobe.
REQ-010 SHALL have port load_val, input, DIGITS*DW: load value; digit 0 in the LSBs.
REQ-011 SHALL have port count, output, DIGITS*DW: registered counter value; digit 0 in the LSBs.
REQ-012 SHALL have port tick, output, 1: combinational step strobe.
REQ-013 SHALL have port carry, output, 1: registered full-wrap pulse.

Function
REQ-014 Prescaler SHALL be a counter of width clog2(DIV), minimum 1 bit.
REQ-015 Prescaler SHALL advance by 1 per clk while en=1 and hold while en=0.
REQ-016 Prescaler SHALL wrap from DIV-1 to 0.
REQ-017 tick SHALL equal en & (prescaler==DIV-1) & ~load.
REQ-018 With DIV=1, tick SHALL equal en & ~load in every cycle.
REQ-019 On tick with up=1, digit 0 SHALL increment.
REQ-020 On tick with up=1, digit i SHALL increment only when every digit below i equals MOD-1.
REQ-021 On tick with up=1, a digit at MOD-1 that steps SHALL wrap to 0.
REQ-022 On tick with up=0, digit 0 SHALL decrement.
REQ-023 On tick with up=0, digit i SHALL decrement only when every digit below i equals 0.
REQ-024 On tick with up=0, a digit at 0 that steps SHALL wrap to MOD-1.
REQ-025 count SHALL update on the clk edge that ends the tick cycle, i.e. latency 1.
REQ-026 up SHALL be sampled only in tick cycles; a mid-interval direction change SHALL NOT disturb the prescaler.
REQ-027 carry SHALL be 1 for exactly one clk, aligned with the new count, after an up step from all digits = MOD-1 to all digits = 0.
REQ-028 carry SHALL be 1 for exactly one clk, aligned with the new count, after a down step from all digits = 0 to all digits = MOD-1.
REQ-029 carry SHALL be 0 in every other cycle.
REQ-030 load SHALL have priority over tick.
REQ-031 On load, count SHALL take load_val on the next edge, independent of en.
REQ-032 On load, the prescaler SHALL clear to 0.
REQ-033 On load, carry SHALL be 0.
REQ-034 On load, any load_val digit >= MOD SHALL be loaded as 0.
REQ-035 count digits SHALL always lie in 0..MOD-1.

Reset
REQ-036 While rst=1, on each edge: count=0, prescaler=0, carry=0.
REQ-037 rst SHALL have priority over load, en and tick.
REQ-038 tick SHALL evaluate to 0 while rst=1.
REQ-039 A reset asserted mid-interval SHALL discard the partial prescale, so the first tick after reset comes DIV cycles after the first en=1 cycle.

Structure
REQ-040 Package counter_pkg SHALL hold the default DIGITS, DW, MOD and DIV constants.
REQ-041 counter_pkg SHALL hold a clog2-based prescaler width function.
REQ-042 Each digit SHALL be one instance of sub-module modn_digit, ports: clk, rst, step, up, load, ld_val, q, at_term.
REQ-043 modn_digit at_term SHALL be (q==MOD-1) when up=1 and (q==0) when up=0.
REQ-044 Step enables SHALL be chained through at_term: digit i step = tick & AND of at_term for all digits below i.
REQ-045 The prescaler and the carry register SHALL live in the top level.

Verification
REQ-046 DIV=1, MOD=10, DIGITS=2, rst then en=1, up=1 for 100 clk -> count 0x00..0x99 then 0x00; carry high only in the cycle showing 0x00.
REQ-047 From 0x00, up=0, en=1 -> count 0x99, 0x98, ...; carry pulses with 0x99.
REQ-048 DIV=4, en=1 -> tick every 4th clk; en=0 for 3 clk mid-interval -> prescaler and count hold; stepping resumes with no lost or extra steps.
REQ-049 load=1 with load_val=0x47 in a tick cycle -> count=0x47 next clk, no step; next tick DIV clk later; load_val=0x5C -> count=0x50.
REQ-050 Count 0x98 up; assert rst and load together -> next clk count=0x00, carry=0; MOD=16, DW=4 -> full 0x00..0xFF binary sweep with carry at 0xFF->0x00.
